// File: rtl/axi4_util_pkg.sv
// Shared AXI4 helpers: field widths, burst-type encodings and the read splitter FSM states.
`include "noc_axi4_bridge_define.vh"

package axi4_util_pkg;

  localparam int unsigned IdW    = `AXI4_ID_WIDTH;
  localparam int unsigned AddrW  = `AXI4_ADDR_WIDTH;
  localparam int unsigned LenW   = `AXI4_LEN_WIDTH;
  localparam int unsigned SizeW  = `AXI4_SIZE_WIDTH;
  localparam int unsigned BurstW = `AXI4_BURST_WIDTH;
  localparam int unsigned DataW  = `AXI4_DATA_WIDTH;
  localparam int unsigned RespW  = `AXI4_RESP_WIDTH;

  localparam logic [BurstW-1:0] BurstFixed = BurstW'(0);
  localparam logic [BurstW-1:0] BurstIncr  = BurstW'(1);
  localparam logic [BurstW-1:0] BurstWrap  = BurstW'(2);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StData
  } rd_state_e;

endpackage

// File: rtl/axi4_burst_calc.sv
// Combinational child-burst length and post-child address for the read splitter.
module axi4_burst_calc
  import axi4_util_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic [8:0]        remaining,
  input  logic [AddrW-1:0]  cur_addr,
  input  logic [SizeW-1:0]  size,
  input  logic [BurstW-1:0] burst,
  output logic [8:0]        child_beats,
  output logic [LenW-1:0]   child_len,
  output logic [AddrW-1:0]  next_addr
);

  localparam logic [8:0] MaxBeats = 9'(MAX_BEATS);

  logic [8:0] len_m1;

  always_comb begin
    // Only INCR bursts may be cut; FIXED/WRAP go out whole.
    child_beats = remaining;
    if (burst == BurstIncr && remaining > MaxBeats) begin
      child_beats = MaxBeats;
    end
    len_m1    = child_beats - 9'd1;
    child_len = len_m1[LenW-1:0];
    next_addr = cur_addr + (AddrW'(child_beats) << size);
  end

endmodule

// File: rtl/noc_axi4_bridge_define.vh
// AXI4 field widths shared by the NoC bridge blocks.
`ifndef NOC_AXI4_BRIDGE_DEFINE_VH
`define NOC_AXI4_BRIDGE_DEFINE_VH

`define AXI4_ID_WIDTH    4
`define AXI4_ADDR_WIDTH  32
`define AXI4_LEN_WIDTH   8
`define AXI4_SIZE_WIDTH  3
`define AXI4_BURST_WIDTH 2
`define AXI4_DATA_WIDTH  64
`define AXI4_RESP_WIDTH  2

`endif

// File: rtl/axi4_rd_splitter.sv
// Splits long upstream INCR read bursts into downstream bursts of at most MAX_BEATS beats,
// with a zero-latency combinational R path and rlast masked on all but the final child.
module axi4_rd_splitter
  import axi4_util_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IdW-1:0]    s_arid,
  input  logic [AddrW-1:0]  s_araddr,
  input  logic [LenW-1:0]   s_arlen,
  input  logic [SizeW-1:0]  s_arsize,
  input  logic [BurstW-1:0] s_arburst,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [IdW-1:0]    s_rid,
  output logic [DataW-1:0]  s_rdata,
  output logic [RespW-1:0]  s_rresp,
  output logic              s_rlast,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [IdW-1:0]    m_arid,
  output logic [AddrW-1:0]  m_araddr,
  output logic [LenW-1:0]   m_arlen,
  output logic [SizeW-1:0]  m_arsize,
  output logic [BurstW-1:0] m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [IdW-1:0]    m_rid,
  input  logic [DataW-1:0]  m_rdata,
  input  logic [RespW-1:0]  m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready
);

  rd_state_e         state_q, state_d;
  logic [IdW-1:0]    id_q;
  logic [AddrW-1:0]  addr_q;
  logic [SizeW-1:0]  size_q;
  logic [BurstW-1:0] burst_q;
  logic [8:0]        rem_q;

  logic [8:0]        child_beats;
  logic [LenW-1:0]   child_len;
  logic [AddrW-1:0]  next_addr;
  logic              last_child;
  logic              ar_fire;
  logic              child_done;

  axi4_burst_calc #(
    .MAX_BEATS (MAX_BEATS)
  ) u_burst_calc (
    .remaining   (rem_q),
    .cur_addr    (addr_q),
    .size        (size_q),
    .burst       (burst_q),
    .child_beats (child_beats),
    .child_len   (child_len),
    .next_addr   (next_addr)
  );

  assign last_child = (rem_q == child_beats);

  assign m_arid    = id_q;
  assign m_araddr  = addr_q;
  assign m_arlen   = child_len;
  assign m_arsize  = size_q;
  assign m_arburst = burst_q;

  assign s_rid   = m_rid;
  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;

  always_comb begin
    state_d    = state_q;
    s_arready  = 1'b0;
    m_arvalid  = 1'b0;
    s_rvalid   = 1'b0;
    m_rready   = 1'b0;
    s_rlast    = 1'b0;
    ar_fire    = 1'b0;
    child_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        s_arready = 1'b1;
        if (s_arvalid) begin
          ar_fire = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = StData;
      end
      StData: begin
        s_rvalid = m_rvalid;
        m_rready = s_rready;
        s_rlast  = m_rlast & last_child;
        if (m_rvalid && s_rready && m_rlast) begin
          child_done = 1'b1;
          state_d    = last_child ? StIdle : StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
    // Keep every handshake quiet while reset is asserted, before the state register clears.
    if (!rst_n) begin
      s_arready  = 1'b0;
      m_arvalid  = 1'b0;
      s_rvalid   = 1'b0;
      m_rready   = 1'b0;
      s_rlast    = 1'b0;
      ar_fire    = 1'b0;
      child_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      id_q    <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ar_fire) begin
        id_q    <= s_arid;
        addr_q  <= s_araddr;
        size_q  <= s_arsize;
        burst_q <= s_arburst;
        rem_q   <= {1'b0, s_arlen} + 9'd1;
      end else if (child_done) begin
        rem_q  <= rem_q - child_beats;
        addr_q <= next_addr;
      end
    end
  end

endmodule

// File: tb/tb_axi4_rd_splitter.sv
// Directed bench for axi4_rd_splitter: scoreboarded AR and R streams against a simple memory slave.
module tb_axi4_rd_splitter;
  import axi4_util_pkg::*;

  localparam int unsigned MaxBeats = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [IdW-1:0]    s_arid;
  logic [AddrW-1:0]  s_araddr;
  logic [LenW-1:0]   s_arlen;
  logic [SizeW-1:0]  s_arsize;
  logic [BurstW-1:0] s_arburst;
  logic              s_arvalid;
  logic              s_arready;
  logic [IdW-1:0]    s_rid;
  logic [DataW-1:0]  s_rdata;
  logic [RespW-1:0]  s_rresp;
  logic              s_rlast;
  logic              s_rvalid;
  logic              s_rready;
  logic [IdW-1:0]    m_arid;
  logic [AddrW-1:0]  m_araddr;
  logic [LenW-1:0]   m_arlen;
  logic [SizeW-1:0]  m_arsize;
  logic [BurstW-1:0] m_arburst;
  logic              m_arvalid;
  logic              m_arready;
  logic [IdW-1:0]    m_rid;
  logic [DataW-1:0]  m_rdata;
  logic [RespW-1:0]  m_rresp;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;

  always #5 clk = ~clk;

  axi4_rd_splitter #(
    .MAX_BEATS (MaxBeats)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_arid    (s_arid),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_arsize  (s_arsize),
    .s_arburst (s_arburst),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rid     (s_rid),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rlast   (s_rlast),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .m_arid    (m_arid),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arsize  (m_arsize),
    .m_arburst (m_arburst),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rid     (m_rid),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready)
  );

  typedef struct packed {
    logic [AddrW-1:0]  addr;
    logic [LenW-1:0]   len;
    logic [IdW-1:0]    id;
    logic [SizeW-1:0]  size;
    logic [BurstW-1:0] burst;
  } ar_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [RespW-1:0] resp;
    logic             last;
    logic [IdW-1:0]   id;
  } r_t;

  int  checks = 0;
  int  failures = 0;
  ar_t exp_ar_q[$];
  r_t  exp_r_q[$];
  int  ar_delay = 0;
  bit  toggle_rdy = 0;
  bit  err_mode = 0;
  bit  stray = 0;
  int  ar_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RespW-1:0] resp_of(input int beat, input bit en);
    if (!en) return '0;
    if (beat == 1) return 2'b10;
    if (beat == 3) return 2'b11;
    return '0;
  endfunction

  function automatic logic [63:0] ar_bits();
    return 64'({m_araddr, m_arlen, m_arid, m_arsize, m_arburst});
  endfunction

  // Expected children and upstream beats for one parent burst.
  task automatic plan(input logic [IdW-1:0] id, input logic [AddrW-1:0] addr,
                      input int len, input logic [SizeW-1:0] size,
                      input logic [BurstW-1:0] burst);
    int               rem;
    int               beats;
    logic [AddrW-1:0] a;
    ar_t              ea;
    r_t               er;
    rem = len + 1;
    a   = addr;
    while (rem > 0) begin
      beats = (burst == BurstIncr && rem > MaxBeats) ? MaxBeats : rem;
      ea = '{addr: a, len: LenW'(beats - 1), id: id, size: size, burst: burst};
      exp_ar_q.push_back(ea);
      for (int b = 0; b < beats; b++) begin
        er = '{data: DataW'({a, 32'(b)}), resp: resp_of(b, err_mode),
               last: (rem == beats) && (b == beats - 1), id: id};
        exp_r_q.push_back(er);
      end
      a   = a + (AddrW'(beats) << size);
      rem = rem - beats;
    end
  endtask

  // Downstream memory slave and upstream R-ready driver.
  initial begin : slave
    bit               ar_hs, r_hs, have;
    logic [AddrW-1:0] b_addr, sm_addr;
    logic [LenW-1:0]  b_len, sm_len;
    logic [IdW-1:0]   b_id, sm_id;
    int               beat, wait_cnt;
    have = 0; beat = 0; wait_cnt = 0;
    b_addr = '0; b_len = '0; b_id = '0;
    m_arready = 0; m_rvalid = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0;
    s_rready = 1;
    forever begin
      @(negedge clk);
      ar_hs   = m_arvalid && m_arready;
      r_hs    = m_rvalid && m_rready;
      sm_addr = m_araddr;
      sm_len  = m_arlen;
      sm_id   = m_arid;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        have = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0; wait_cnt = 0;
      end else begin
        if (ar_hs) begin
          have = 1; b_addr = sm_addr; b_len = sm_len; b_id = sm_id; beat = 0;
          m_arready = 0; wait_cnt = 0;
        end
        if (r_hs && have) begin
          if (beat == int'(b_len)) have = 0;
          else beat++;
        end
        if (m_arvalid && !m_arready) begin
          if (wait_cnt >= ar_delay) m_arready = 1;
          else wait_cnt++;
        end
        if (have) begin
          m_rvalid = 1; m_rid = b_id; m_rdata = DataW'({b_addr, 32'(beat)});
          m_rresp = resp_of(beat, err_mode); m_rlast = (beat == int'(b_len));
        end else if (stray) begin
          m_rvalid = 1; m_rid = '1; m_rdata = '1; m_rresp = '0; m_rlast = 1;
        end else begin
          m_rvalid = 0; m_rlast = 0;
        end
      end
      s_rready = toggle_rdy ? ~s_rready : 1'b1;
    end
  end

  // Downstream AR monitor: order, fields and stability while stalled.
  logic [63:0] ar_prev;
  bit          ar_wait = 0;
  always @(negedge clk) begin
    ar_t e;
    if (!rst_n) begin
      ar_wait = 0;
    end else begin
      if (m_arvalid && ar_wait) chk("ar_stable", ar_bits(), ar_prev);
      if (m_arvalid && m_arready) begin
        ar_seen++;
        ar_wait = 0;
        if (exp_ar_q.size() == 0) begin
          chk("ar_unexpected", ar_bits(), 64'd0);
        end else begin
          e = exp_ar_q.pop_front();
          chk("ar_addr", 64'(m_araddr), 64'(e.addr));
          chk("ar_len", 64'(m_arlen), 64'(e.len));
          chk("ar_id", 64'(m_arid), 64'(e.id));
          chk("ar_size", 64'(m_arsize), 64'(e.size));
          chk("ar_burst", 64'(m_arburst), 64'(e.burst));
        end
      end else if (m_arvalid) begin
        ar_wait = 1;
        ar_prev = ar_bits();
      end else begin
        ar_wait = 0;
      end
    end
  end

  // Upstream R monitor.
  always @(negedge clk) begin
    r_t e;
    if (rst_n && s_rvalid && s_rready) begin
      if (exp_r_q.size() == 0) begin
        chk("r_unexpected", s_rdata, 64'd0);
      end else begin
        e = exp_r_q.pop_front();
        chk("r_data", 64'(s_rdata), 64'(e.data));
        chk("r_resp", 64'(s_rresp), 64'(e.resp));
        chk("r_last", 64'(s_rlast), 64'(e.last));
        chk("r_id", 64'(s_rid), 64'(e.id));
      end
    end
  end

  task automatic send_ar(input logic [IdW-1:0] id, input logic [AddrW-1:0] addr,
                         input int len, input logic [SizeW-1:0] size,
                         input logic [BurstW-1:0] burst);
    bit ok;
    plan(id, addr, len, size, burst);
    @(posedge clk);
    #1;
    s_arid = id; s_araddr = addr; s_arlen = LenW'(len); s_arsize = size; s_arburst = burst;
    s_arvalid = 1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_arready) begin
        ok = 1;
        break;
      end
    end
    chk("ar_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    s_arvalid = 0;
    @(negedge clk);
    chk("arready_busy", 64'(s_arready), 64'd0);
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_r_q.size() == 0 && exp_ar_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk(tag, 64'(ok), 64'd1);
    @(negedge clk);
    chk("idle_arready", 64'(s_arready), 64'd1);
  endtask

  initial begin : stim
    bit ok;
    s_arvalid = 0; s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    rst_n = 0;
    @(negedge clk);
    chk("rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_mrready", 64'(m_rready), 64'd0);
    chk("rst_rlast", 64'(s_rlast), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("post_rst_arready", 64'(s_arready), 64'd1);
    chk("post_rst_arvalid", 64'(m_arvalid), 64'd0);

    ar_seen = 0;
    send_ar(4'h3, 32'h1000, 63, 3'd6, BurstIncr);
    wait_done("len63_done");
    chk("len63_ar_count", 64'(ar_seen), 64'd4);

    ar_seen = 0;
    send_ar(4'h1, 32'h200, 20, 3'd3, BurstIncr);
    wait_done("len20_done");
    chk("len20_ar_count", 64'(ar_seen), 64'd2);

    err_mode = 1;
    ar_seen = 0;
    send_ar(4'h7, 32'h40, 7, 3'd2, BurstIncr);
    wait_done("len7_err_done");
    chk("len7_ar_count", 64'(ar_seen), 64'd1);
    err_mode = 0;

    ar_seen = 0;
    send_ar(4'h2, 32'h30, 3, 3'd4, BurstWrap);
    wait_done("wrap_done");
    chk("wrap_ar_count", 64'(ar_seen), 64'd1);

    ar_seen = 0;
    send_ar(4'h9, 32'h500, 20, 3'd2, BurstFixed);
    wait_done("fixed_done");
    chk("fixed_ar_count", 64'(ar_seen), 64'd1);

    ar_seen = 0;
    send_ar(4'hA, 32'hFFFF_FFC0, 31, 3'd2, BurstIncr);
    wait_done("addr_wrap_done");
    chk("addr_wrap_ar_count", 64'(ar_seen), 64'd2);

    toggle_rdy = 1;
    ar_delay = 5;
    ar_seen = 0;
    send_ar(4'h5, 32'h100, 40, 3'd2, BurstIncr);
    wait_done("stall_done");
    chk("stall_ar_count", 64'(ar_seen), 64'd3);
    toggle_rdy = 0;
    ar_delay = 0;

    // Downstream R valid while idle must be ignored.
    stray = 1;
    repeat (2) @(negedge clk);
    chk("stray_mrready", 64'(m_rready), 64'd0);
    chk("stray_srvalid", 64'(s_rvalid), 64'd0);
    chk("stray_arready", 64'(s_arready), 64'd1);
    stray = 0;
    repeat (2) @(posedge clk);

    ar_seen = 0;
    send_ar(4'h4, 32'h2000, 63, 3'd2, BurstIncr);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ar_seen >= 2) begin
        ok = 1;
        break;
      end
    end
    chk("second_child_reached", 64'(ok), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    @(negedge clk);
    chk("midrst_arvalid", 64'(m_arvalid), 64'd0);
    chk("midrst_srvalid", 64'(s_rvalid), 64'd0);
    chk("midrst_mrready", 64'(m_rready), 64'd0);
    chk("midrst_rlast", 64'(s_rlast), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    exp_ar_q.delete();
    exp_r_q.delete();
    @(negedge clk);
    chk("midrst_rel_arready", 64'(s_arready), 64'd1);
    chk("midrst_rel_arvalid", 64'(m_arvalid), 64'd0);

    ar_seen = 0;
    send_ar(4'h6, 32'h3000, 0, 3'd3, BurstIncr);
    wait_done("after_rst_done");
    chk("after_rst_ar_count", 64'(ar_seen), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi4_rd_splitter.md
AXI4_RD_SPLITTER -- requirements
Module: axi4_rd_splitter

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 16, max beats per downstream burst; power of two, 1..256.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports s_arid/s_araddr/s_arlen/s_arsize/s_arburst  input  `AXI4_ID/ADDR/LEN/SIZE/BURST_WIDTH  upstream read address.
REQ-005 SHALL have ports s_arvalid  input  1  and s_arready  output  1  upstream AR handshake.
REQ-006 SHALL have ports s_rid/s_rdata/s_rresp/s_rlast/s_rvalid  output  `AXI4_ID/DATA/RESP_WIDTH,1,1  upstream read data; s_rready  input  1.
REQ-007 SHALL have ports m_arid/m_araddr/m_arlen/m_arsize/m_arburst/m_arvalid  output  same widths  downstream read address; m_arready  input  1.
REQ-008 SHALL have ports m_rid/m_rdata/m_rresp/m_rlast/m_rvalid  input  same widths  downstream read data; m_rready  output  1.
REQ-009 SHALL drive unlisted downstream AR fields (lock, cache, prot, qos, region, user) to 0 at instantiation level; they are not ports of this block.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, DATA; one parent burst outstanding at a time.
REQ-011 IDLE: s_arready=1, m_arvalid=0, s_rvalid=0, m_rready=0; on s_arvalid&s_arready latch id, addr, size, burst, remaining=arlen+1 (9 bits), go ISSUE next cycle.
REQ-012 ISSUE: m_arvalid=1 held stable until m_arready; m_araddr=cur_addr, m_arid=latched id, m_arsize=latched size, m_arburst=latched burst, m_arlen=min(remaining,MAX_BEATS)-1; on m_arready go DATA.
REQ-013 Non-INCR parent (FIXED/WRAP): SHALL issue exactly one downstream burst with m_arlen=parent arlen, no split.
REQ-014 DATA: R path combinational: s_rdata/s_rresp/s_rid=m_r*, s_rvalid=m_rvalid, m_rready=s_rready; no buffering, zero added latency.
REQ-015 s_rlast SHALL equal m_rlast AND (this child is the final child); intermediate child rlast SHALL be masked to 0.
REQ-016 On m_rvalid&m_rready&m_rlast: remaining-=child beats; cur_addr+=child_beats<<size (ADDR_WIDTH wrap, no carry out); if remaining==0 go IDLE else go ISSUE.
REQ-017 m_rresp SLVERR/DECERR SHALL be forwarded per beat unchanged; error does not abort remaining children.
REQ-018 s_arready SHALL be 0 in ISSUE and DATA; a new AR is accepted no earlier than the cycle after final parent beat.
REQ-019 Downstream bursts never cross a 4 KB boundary if the parent does not; block SHALL NOT check parent 4 KB legality.
REQ-020 m_rvalid outside DATA is a protocol error; block SHALL hold m_rready=0 and ignore it.

Reset
REQ-021 On rst_n=0 at a clk edge: state=IDLE, remaining=0, cur_addr=0, latched fields=0; s_arready=1 and m_arvalid=0 in the first cycle after reset release.
REQ-022 Reset mid-burst SHALL abandon the burst without further downstream AR; downstream is reset by the same rst_n.
REQ-023 All outputs during reset: m_arvalid=0, s_rvalid=0, m_rready=0, s_rlast=0.

Structure
REQ-024 Width macros SHALL come from noc_axi4_bridge_define.vh; FSM state enum and AXI burst-type constants (FIXED=0, INCR=1, WRAP=2) SHALL reside in shared package axi4_util_pkg.
REQ-025 Single sub-module natural: axi4_burst_calc (combinational child length and next address); no other hierarchy.
REQ-026 Target size 120-400 RTL lines.

Verification
REQ-027 MAX_BEATS=16, AR addr=0x1000 len=63 size=6 INCR -> 4 downstream ARs at 0x1000/0x1400/0x1800/0x1C00 len=15; 64 upstream beats, s_rlast only on beat 64.
REQ-028 len=20 size=3 addr=0x200 -> ARs len=15 @0x200, len=4 @0x280; s_rlast on beat 21.
REQ-029 len=7 (<MAX_BEATS) -> single AR len=7, upstream R identical to downstream incl. rlast.
REQ-030 WRAP len=3 addr=0x30 size=4 -> single AR, unchanged fields, no split.
REQ-031 s_rready toggled 0/1 every cycle and m_arready delayed 5 cycles -> no lost/duplicated beats, m_ar* stable while waiting, data order preserved.
REQ-032 rst_n=0 during second child of len=63 burst -> next cycle after release s_arready=1, m_arvalid=0; new AR len=0 completes normally.
